// File: rtl/enc_stream.sv
// Streaming SEC-DED encoder with per-word width tag, optional bit-error injection,
// a 2-entry output buffer and a saturating accepted-word counter.
module enc_stream #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ena,
  input  logic [1:0]                    codeword_width,
  input  logic [DATA_WIDTH-1:0]         data_in,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [1:0]                    inj_mode,
  input  logic [$clog2(DATA_WIDTH)-1:0] inj_pos,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         data_out,
  output logic [1:0]                    out_cw,
  output logic                          out_err,
  output logic [CNT_WIDTH-1:0]          word_cnt
);

  // Mask of data bits whose Hamming position has bit `bit_i` set. Data bit j sits
  // at the (j+1)-th non-power-of-two position counting up from 3.
  function automatic logic [63:0] par_mask(input int kd, input int bit_i);
    logic [63:0] m;
    int          j;
    m = '0;
    j = 0;
    for (int p = 3; p < 128; p++) begin
      if (((p & (p - 1)) != 0) && (j < kd)) begin
        if (((p >> bit_i) & 1) != 0) begin
          m = m | (64'd1 << j);
        end
        j++;
      end
    end
    return m;
  endfunction

  logic [DATA_WIDTH-1:0] cw_enc [4];
  logic [3:0]            width_ok;

  for (genvar gi = 0; gi < 4; gi++) begin : g_width
    localparam int N    = 8 << gi;
    localparam int LOGN = 3 + gi;
    localparam int KD   = N - LOGN - 1;

    if (N <= DATA_WIDTH) begin : g_legal
      logic [LOGN:0]   par;
      logic [N-1:0]    cw_raw;
      logic [N-1:0]    flip;
      logic [LOGN-1:0] pos_a;
      logic [LOGN-1:0] pos_b;

      for (genvar gb = 0; gb < LOGN; gb++) begin : g_par
        localparam logic [63:0] MASK = par_mask(KD, gb);
        assign par[gb] = ^(data_in[KD-1:0] & MASK[KD-1:0]);
      end
      assign par[LOGN] = ^{data_in[KD-1:0], par[LOGN-1:0]};
      assign cw_raw    = {data_in[KD-1:0], par};

      // Injection positions wrap modulo N, so only the low LOGN bits matter.
      assign pos_a = inj_pos[LOGN-1:0];
      assign pos_b = pos_a + 1'b1;

      always_comb begin
        flip = '0;
        if (inj_mode == 2'b01 || inj_mode == 2'b10) begin
          flip[pos_a] = 1'b1;
        end
        if (inj_mode == 2'b10) begin
          flip[pos_b] = 1'b1;
        end
      end

      assign cw_enc[gi]   = DATA_WIDTH'(cw_raw ^ flip);
      assign width_ok[gi] = 1'b1;
    end else begin : g_illegal
      assign cw_enc[gi]   = '0;
      assign width_ok[gi] = 1'b0;
    end
  end

  // Data bits above the widest legal K, and unused inj_pos bits, are ignored.
  logic unused_hi;
  assign unused_hi = ^{data_in, inj_pos};

  logic [DATA_WIDTH-1:0] enc_sel;
  logic                  err_sel;

  assign enc_sel = cw_enc[codeword_width];
  assign err_sel = ~width_ok[codeword_width];

  logic [DATA_WIDTH-1:0] fifo_data_reg [2];
  logic [1:0]            fifo_cw_reg   [2];
  logic                  fifo_err_reg  [2];
  logic                  wr_ptr_reg;
  logic                  rd_ptr_reg;
  logic [1:0]            count_reg;
  logic [CNT_WIDTH-1:0]  word_cnt_reg;
  logic                  push;
  logic                  pop;

  // Ready depends only on stored state and enable, never on out_ready.
  assign in_ready  = rst & ena & (count_reg != 2'd2);
  assign out_valid = (count_reg != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign data_out = fifo_data_reg[rd_ptr_reg];
  assign out_cw   = fifo_cw_reg[rd_ptr_reg];
  assign out_err  = fifo_err_reg[rd_ptr_reg];
  assign word_cnt = word_cnt_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        fifo_data_reg[i] <= '0;
        fifo_cw_reg[i]   <= 2'b00;
        fifo_err_reg[i]  <= 1'b0;
      end
      wr_ptr_reg   <= 1'b0;
      rd_ptr_reg   <= 1'b0;
      count_reg    <= 2'd0;
      word_cnt_reg <= '0;
    end else begin
      if (push) begin
        fifo_data_reg[wr_ptr_reg] <= enc_sel;
        fifo_cw_reg[wr_ptr_reg]   <= codeword_width;
        fifo_err_reg[wr_ptr_reg]  <= err_sel;
        wr_ptr_reg                <= ~wr_ptr_reg;
        if (word_cnt_reg != {CNT_WIDTH{1'b1}}) begin
          word_cnt_reg <= word_cnt_reg + 1'b1;
        end
      end
      if (pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: tb/tb_enc_stream.sv
// Directed bench for enc_stream: default 32-bit instance plus a 16-bit instance
// with a 4-bit counter for illegal-width and saturation cases.
module tb_enc_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        a_ena, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_err;
  logic [1:0]  a_cw, a_inj_mode, a_out_cw;
  logic [31:0] a_data_in, a_data_out;
  logic [4:0]  a_inj_pos;
  logic [15:0] a_word_cnt;

  logic        b_ena, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_err;
  logic [1:0]  b_cw, b_inj_mode, b_out_cw;
  logic [15:0] b_data_in, b_data_out;
  logic [3:0]  b_inj_pos;
  logic [3:0]  b_word_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  enc_stream #(.DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .ena(a_ena), .codeword_width(a_cw), .data_in(a_data_in),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .inj_mode(a_inj_mode), .inj_pos(a_inj_pos),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .data_out(a_data_out),
    .out_cw(a_out_cw), .out_err(a_out_err), .word_cnt(a_word_cnt)
  );

  enc_stream #(.DATA_WIDTH(16), .CNT_WIDTH(4)) dut16 (
    .clk(clk), .rst(rst), .ena(b_ena), .codeword_width(b_cw), .data_in(b_data_in),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .inj_mode(b_inj_mode), .inj_pos(b_inj_pos),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .data_out(b_data_out),
    .out_cw(b_out_cw), .out_err(b_out_err), .word_cnt(b_word_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [1:0] cw, input logic [31:0] d,
                         input logic [1:0] m, input logic [4:0] p);
    a_in_valid = v; a_cw = cw; a_data_in = d; a_inj_mode = m; a_inj_pos = p;
  endtask

  task automatic drive_b(input logic v, input logic [1:0] cw, input logic [15:0] d);
    b_in_valid = v; b_cw = cw; b_data_in = d; b_inj_mode = 2'b00; b_inj_pos = 4'd0;
  endtask

  initial begin
    rst = 1'b0;
    a_ena = 1'b1; a_out_ready = 1'b0;
    b_ena = 1'b1; b_out_ready = 1'b0;
    drive_a(1'b0, 2'b00, 32'h0, 2'b00, 5'd0);
    drive_b(1'b0, 2'b00, 16'h0);
    repeat (2) tick();

    check("rst_in_ready", a_in_ready, 0);
    check("rst_out_valid", a_out_valid, 0);
    check("rst_data_out", a_data_out, 0);
    check("rst_out_cw", a_out_cw, 0);
    check("rst_out_err", a_out_err, 0);
    check("rst_word_cnt", a_word_cnt, 0);
    rst = 1'b1;
    #1;
    check("post_rst_in_ready", a_in_ready, 1);

    // 8-bit stream at full rate
    a_out_ready = 1'b1;
    drive_a(1'b1, 2'b00, 32'h1, 2'b00, 5'd0);
    tick();
    check("w8_0x1", a_data_out, 64'h1B);
    check("w8_0x1_valid", a_out_valid, 1);
    check("w8_0x1_cw", a_out_cw, 0);
    drive_a(1'b1, 2'b00, 32'hF, 2'b00, 5'd0);
    tick();
    check("w8_0xF", a_data_out, 64'hFF);
    drive_a(1'b1, 2'b00, 32'h0, 2'b00, 5'd0);
    tick();
    check("w8_0x0", a_data_out, 64'h00);
    check("w8_0x0_valid", a_out_valid, 1);
    drive_a(1'b0, 2'b00, 32'h0, 2'b00, 5'd0);
    tick();
    check("drained_valid", a_out_valid, 0);

    // Other widths and injection
    drive_a(1'b1, 2'b01, 32'h001, 2'b00, 5'd0);
    tick();
    check("w16_data", a_data_out, 64'h33);
    check("w16_cw", a_out_cw, 1);
    check("w16_err", a_out_err, 0);
    drive_a(1'b1, 2'b00, 32'h1, 2'b01, 5'd2);
    tick();
    check("inj_single", a_data_out, 64'h1F);
    drive_a(1'b1, 2'b00, 32'h1, 2'b10, 5'd7);
    tick();
    check("inj_double_wrap", a_data_out, 64'h9A);
    drive_a(1'b1, 2'b10, 32'h1, 2'b00, 5'd0);
    tick();
    check("w32_data", a_data_out, 64'h63);
    check("w32_cw", a_out_cw, 2);
    drive_a(1'b1, 2'b11, 32'h5, 2'b01, 5'd0);
    tick();
    check("w64_illegal_err", a_out_err, 1);
    check("w64_illegal_data", a_data_out, 0);
    check("w64_illegal_cw", a_out_cw, 3);
    drive_a(1'b0, 2'b00, 32'h0, 2'b00, 5'd0);
    tick();
    check("idle_valid", a_out_valid, 0);
    check("cnt_after_stream", a_word_cnt, 8);

    // Enable low blocks accepts
    a_ena = 1'b0;
    drive_a(1'b1, 2'b00, 32'h1, 2'b00, 5'd0);
    #1;
    check("ena_low_in_ready", a_in_ready, 0);
    tick();
    check("ena_low_no_word", a_out_valid, 0);
    check("ena_low_cnt", a_word_cnt, 8);
    a_ena = 1'b1;
    drive_a(1'b0, 2'b00, 32'h0, 2'b00, 5'd0);

    // Backpressure
    a_out_ready = 1'b0;
    drive_a(1'b1, 2'b00, 32'h2, 2'b00, 5'd0);
    tick();
    check("bp_ready_after_1", a_in_ready, 1);
    check("bp_head_1", a_data_out, 64'h2D);
    drive_a(1'b1, 2'b00, 32'h3, 2'b00, 5'd0);
    tick();
    check("bp_ready_after_2", a_in_ready, 0);
    check("bp_head_2", a_data_out, 64'h2D);
    check("bp_cnt_2", a_word_cnt, 10);
    drive_a(1'b1, 2'b00, 32'h4, 2'b00, 5'd0);
    tick();
    check("bp_stall_ready", a_in_ready, 0);
    check("bp_stall_head", a_data_out, 64'h2D);
    check("bp_stall_cnt", a_word_cnt, 10);
    a_out_ready = 1'b1;
    tick();
    check("bp_drain_second", a_data_out, 64'h36);
    check("bp_drain_ready", a_in_ready, 1);
    check("bp_drain_cnt", a_word_cnt, 10);
    tick();
    check("bp_resume_head", a_data_out, 64'h4E);
    check("bp_resume_cnt", a_word_cnt, 11);
    drive_a(1'b0, 2'b00, 32'h0, 2'b00, 5'd0);
    tick();
    check("bp_empty", a_out_valid, 0);

    // Asynchronous reset while holding two words
    a_out_ready = 1'b0;
    drive_a(1'b1, 2'b00, 32'h1, 2'b00, 5'd0);
    tick();
    tick();
    drive_a(1'b0, 2'b00, 32'h0, 2'b00, 5'd0);
    check("pre_rst_valid", a_out_valid, 1);
    check("pre_rst_cnt", a_word_cnt, 13);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_valid", a_out_valid, 0);
    check("mid_rst_cnt", a_word_cnt, 0);
    check("mid_rst_data", a_data_out, 0);
    check("mid_rst_in_ready", a_in_ready, 0);
    tick();
    rst = 1'b1;

    // 16-bit instance: illegal 32-bit tag, legal 16-bit, then saturation
    b_out_ready = 1'b1;
    drive_b(1'b1, 2'b10, 16'h1);
    tick();
    check("b_illegal_err", b_out_err, 1);
    check("b_illegal_data", b_data_out, 0);
    check("b_illegal_cw", b_out_cw, 2);
    check("b_illegal_cnt", b_word_cnt, 1);
    drive_b(1'b1, 2'b01, 16'h1);
    tick();
    check("b_w16_data", b_data_out, 64'h33);
    check("b_w16_err", b_out_err, 0);
    check("b_cnt_2", b_word_cnt, 2);
    drive_b(1'b1, 2'b00, 16'hF);
    repeat (18) tick();
    check("b_sat_cnt", b_word_cnt, 15);
    check("b_sat_data", b_data_out, 64'hFF);
    drive_b(1'b0, 2'b00, 16'h0);
    tick();
    check("b_empty", b_out_valid, 0);
    check("b_sat_hold", b_word_cnt, 15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/enc_stream.md
# enc_stream

Streaming, registered successor to the combinational multi-width Hamming encoder. Words arrive over a valid/ready handshake, each tagged with its own codeword width (8/16/32/64, capped by `DATA_WIDTH`). Each word is SEC-DED encoded into a one-cycle registered stage and queued in a 2-entry output buffer. Optional per-word single/double bit-error injection and a saturating word counter make the block the stimulus source for decoder bring-up and BIST.

## Interface
- `DATA_WIDTH`, default 32: maximum codeword width; legal values 8, 16, 32, 64.
- `CNT_WIDTH`, default 16: width of `word_cnt`.
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `ena`  in  1  block enable; low forces `in_ready`=0, buffer still drains.
- `codeword_width`  in  2  per-word width select: 00=8, 01=16, 10=32, 11=64.
- `data_in`  in  DATA_WIDTH  data; LSB-aligned, only low K bits used.
- `in_valid`  in  1  input word valid.
- `in_ready`  out  1  input accept; transfer when `in_valid`&`in_ready`.
- `inj_mode`  in  2  00 none, 01 single flip, 10 double flip, 11 reserved (= none).
- `inj_pos`  in  $clog2(DATA_WIDTH)  codeword bit index for injection.
- `out_valid`  out  1  buffer head valid.
- `out_ready`  in  1  downstream accept.
- `data_out`  out  DATA_WIDTH  codeword, zero-extended above N.
- `out_cw`  out  2  `codeword_width` tag of the head word.
- `out_err`  out  1  head word had an illegal width (N > `DATA_WIDTH`).
- `word_cnt`  out  CNT_WIDTH  accepted-word count, saturating.

## Operation
- Width N = 8·2^`codeword_width`, k = log2(N), data bits K = N−k−1 (4/11/26/57), parity field k+1 bits.
- Data mapping: `data_in` bit j maps to Hamming position pos(j), the (j+1)-th integer in 1..N−1 that is not a power of two (ascending).
- p[i] for i<k: XOR of all `data_in`[j] with bit i of pos(j) set.
- p[k]: XOR of `data_in`[K−1:0] and p[k−1:0] (overall parity).
- Codeword layout: {`data_in`[K−1:0], p[k], …, p[0]}, with p[0] at bit 0.
- Injection applies after encoding, within N bits only:
  - single: flip bit (`inj_pos` mod N);
  - double: also flip bit ((`inj_pos`+1) mod N).
- `inj_mode` and `inj_pos` are sampled together with the data at acceptance.
- Illegal width (N > `DATA_WIDTH`): the word is still accepted and counted; the entry has `data_out`=0, `out_err`=1, and no injection is applied.
- Buffer: 2-entry FIFO of {codeword, tag, err}. Count 0..2; `out_valid` = count≠0.
- `in_ready` = `ena` & (count<2). It is a function of registered state only, with no combinational path from `out_ready`.
- Push and pop in the same cycle: count is unchanged and order is preserved.
- Head fields hold stable while `out_valid`&!`out_ready`.
- `word_cnt` increments on each accepted transfer and saturates at all-ones.

## Timing
- Reset values: `in_ready`=0 while `rst` is low (then `ena`-dependent), `out_valid`=0, `data_out`=0, `out_cw`=0, `out_err`=0, `word_cnt`=0, buffer empty.
- Latency: a word accepted at edge t is visible at the head on cycle t+1 if the buffer was empty or popped at t.
- Throughput: one word per cycle sustained while `out_ready`=1 (count stays ≤1).
- With `out_ready`=0: two words are accepted, then `in_ready` drops the cycle after the second accept.
- Reset asserted mid-stream clears buffer and counter immediately (asynchronously). In-flight words are discarded.
- `ena` dropped: no new accepts from that cycle on; the buffered words drain normally.

## Test plan
- 8-bit width, `data_in`=0x1, 0xF, 0x0, no inject, `out_ready`=1 -> `data_out` 0x1B, 0xFF, 0x00 on consecutive cycles, each 1 cycle after its accept.
- 16-bit width, `data_in`=0x001 -> `data_out`=0x0033, `out_cw`=01, `out_err`=0.
- 8-bit width, `data_in`=0x1, single inject at `inj_pos`=2 -> 0x1F; double inject at `inj_pos`=7 -> bits 7 and 0 flipped -> 0x9A.
- Backpressure: `out_ready`=0, `in_valid`=1 held -> exactly 2 accepts, then `in_ready`=0 and the head stays stable. Raise `out_ready` -> both words drain in order, `word_cnt`=2, accepts resume.
- `DATA_WIDTH`=16 with `codeword_width`=10 -> entry has `out_err`=1, `data_out`=0, `word_cnt` incremented.
- Reset pulse while holding 2 words -> `out_valid`=0 and `word_cnt`=0 immediately. With `CNT_WIDTH`=4, 20 accepts -> `word_cnt`=15.
